// File: rtl/escalonador_chamadas.sv
// SCAN call scheduler for the 4-floor elevator: pending-request bitmap, travel timing
// and the open/dwell/close handshake with the door module.
module escalonador_chamadas #(
    parameter int TEMPO_ANDAR = 4,
    parameter int TEMPO_PORTA = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] andar_chamada,
    input  logic       confirma_chamada,
    input  logic [1:0] andar_destino,
    input  logic       confirma_destino,
    input  logic       porta_aberta,
    input  logic       porta_fechada,
    input  logic       lotado,
    output logic [1:0] andar_atual,
    output logic       subindo,
    output logic       parado,
    output logic       controle_porta,
    output logic [3:0] pendentes
);

    localparam int TA_W = (TEMPO_ANDAR > 1) ? $clog2(TEMPO_ANDAR) : 1;
    localparam int TP_W = $clog2(TEMPO_PORTA + 1);

    localparam logic [TA_W-1:0] VIAGEM_FIM  = TA_W'(TEMPO_ANDAR - 1);
    localparam logic [TA_W-1:0] VIAGEM_UM   = TA_W'(1);
    localparam logic [TP_W-1:0] PORTA_CARGA = TP_W'(TEMPO_PORTA);
    localparam logic [TP_W-1:0] PORTA_UM    = TP_W'(1);

    typedef enum logic [2:0] {
        OCIOSO,
        MOVENDO,
        ABRINDO,
        ESPERA,
        FECHANDO
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [1:0]      andar_q, andar_d;
    logic            subindo_q, subindo_d;
    logic            parado_q, parado_d;
    logic            porta_q, porta_d;
    logic [3:0]      pend_q, pend_d;
    logic [TA_W-1:0] viagem_q, viagem_d;
    logic [TP_W-1:0] espera_q, espera_d;

    logic [3:0]      novos;
    logic [3:0]      pend_mais;
    logic            mesmo_andar;
    logic [1:0]      proximo;

    // True when any bit of mapa lies strictly beyond andar in the direction sobe.
    function automatic logic tem_a_frente(input logic [3:0] mapa,
                                          input logic [1:0] andar,
                                          input logic       sobe);
        logic [3:0] acima;
        logic [3:0] abaixo;
        acima  = mapa & ~((4'b0010 << andar) - 4'b0001);
        abaixo = mapa & ((4'b0001 << andar) - 4'b0001);
        return sobe ? (|acima) : (|abaixo);
    endfunction

    always_comb begin
        novos       = 4'b0000;
        mesmo_andar = 1'b0;
        proximo     = andar_q;
        estado_d    = estado_q;
        andar_d     = andar_q;
        subindo_d   = subindo_q;
        viagem_d    = viagem_q;
        espera_d    = espera_q;

        if (confirma_chamada) begin
            novos[andar_chamada] = 1'b1;
        end
        if (confirma_destino) begin
            novos[andar_destino] = 1'b1;
        end

        // While stopped, a request for the floor we are on drives the door instead of the bitmap.
        if (estado_q != MOVENDO) begin
            mesmo_andar    = novos[andar_q];
            novos[andar_q] = 1'b0;
        end

        pend_mais = pend_q | novos;
        pend_d    = pend_mais;

        case (estado_q)
            OCIOSO: begin
                if (mesmo_andar) begin
                    estado_d = ABRINDO;
                end else if (pend_q != 4'b0000) begin
                    if (!tem_a_frente(pend_q, andar_q, subindo_q)) begin
                        subindo_d = ~subindo_q;
                    end
                    estado_d = MOVENDO;
                    viagem_d = '0;
                end
            end

            MOVENDO: begin
                if (viagem_q == VIAGEM_FIM) begin
                    viagem_d = '0;
                    proximo  = subindo_q ? (andar_q + 2'd1) : (andar_q - 2'd1);
                    andar_d  = proximo;
                    if (pend_mais[proximo]) begin
                        pend_d[proximo] = 1'b0;
                        estado_d        = ABRINDO;
                    end else if (!tem_a_frente(pend_mais, proximo, subindo_q)) begin
                        subindo_d = ~subindo_q;
                    end
                    // The end floors pin the direction so the floor counter can never wrap.
                    if (proximo == 2'd3) begin
                        subindo_d = 1'b0;
                    end else if (proximo == 2'd0) begin
                        subindo_d = 1'b1;
                    end
                end else begin
                    viagem_d = viagem_q + VIAGEM_UM;
                end
            end

            ABRINDO: begin
                if (porta_aberta) begin
                    estado_d = ESPERA;
                    espera_d = PORTA_CARGA;
                end
            end

            ESPERA: begin
                if (mesmo_andar) begin
                    espera_d = PORTA_CARGA;
                end else if (espera_q != '0) begin
                    espera_d = espera_q - PORTA_UM;
                end else if (!lotado) begin
                    estado_d = FECHANDO;
                end
            end

            FECHANDO: begin
                if (mesmo_andar) begin
                    estado_d = ABRINDO;
                end else if (porta_fechada) begin
                    estado_d = OCIOSO;
                end
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase

        parado_d = (estado_d != MOVENDO);
        porta_d  = (estado_d == ABRINDO) || (estado_d == ESPERA);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            andar_q   <= 2'd0;
            subindo_q <= 1'b1;
            parado_q  <= 1'b1;
            porta_q   <= 1'b0;
            pend_q    <= 4'b0000;
            viagem_q  <= '0;
            espera_q  <= '0;
        end else begin
            estado_q  <= estado_d;
            andar_q   <= andar_d;
            subindo_q <= subindo_d;
            parado_q  <= parado_d;
            porta_q   <= porta_d;
            pend_q    <= pend_d;
            viagem_q  <= viagem_d;
            espera_q  <= espera_d;
        end
    end

    assign andar_atual    = andar_q;
    assign subindo        = subindo_q;
    assign parado         = parado_q;
    assign controle_porta = porta_q;
    assign pendentes      = pend_q;

endmodule
